pipelined_chunk_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 35 +++
 rtl/rca_chunk.sv | 51 +++++
 rtl/pipelined_chunk_adder.sv | 176 +++++++++++++++++
 tb/tb_pipelined_chunk_adder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for pipelined_chunk_adder and its chunk adder.
//
//   Contents:
//     PCA_WIDTH_DEF / PCA_STAGES_DEF : default operand width and stage count
//     PCA_MAX_W                      : widest operand a stage record can carry
//     stage_t                        : per-stage register record (valid, carry,
//                                      overflow, skewed a / b_eff, partial sum)
//     chunk_lo()                     : low bit index of chunk s
//
//   stage_t is sized for PCA_MAX_W so one record type serves every legal
//   WIDTH. Bits above WIDTH are held at zero and fall away in synthesis.
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int PCA_WIDTH_DEF  = 32;
    localparam int PCA_STAGES_DEF = 4;
    localparam int PCA_MAX_W      = 64;

    typedef struct packed {
        logic                 valid;  // beat present in this stage
        logic                 carry;  // carry out of the chunk added here
        logic                 ovf;    // signed overflow of the chunk's MSB
        logic [PCA_MAX_W-1:0] a;      // operand A, upper chunks still pending
        logic [PCA_MAX_W-1:0] b;      // effective operand B (inverted on sub)
        logic [PCA_MAX_W-1:0] psum;   // sum chunks finished so far
    } stage_t;

    // Lowest bit of chunk s for a given chunk size.
    function automatic int chunk_lo(input int s, input int chunk);
        return s * chunk;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// -----------------------------------------------------------------------------
// full_a / rca_chunk
//   full_a    : one-bit full adder cell.
//   rca_chunk : CHUNK-bit combinational ripple-carry adder built from full_a.
//
//   rca_chunk ports:
//     a, b       in  [CHUNK-1:0]  chunk operands
//     cin        in  1            carry into bit 0
//     sum        out [CHUNK-1:0]  chunk sum
//     cout       out 1            carry out of bit CHUNK-1
//     carry_msb  out 1            carry into bit CHUNK-1 (for signed overflow)
// -----------------------------------------------------------------------------
module full_a (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module rca_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             carry_msb
);
    // c[i] is the carry into bit i; c[CHUNK] leaves the chunk.
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_a u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout      = c[CHUNK];
    assign carry_msb = c[CHUNK-1];
endmodule

// File: rtl/pipelined_chunk_adder.sv
// -----------------------------------------------------------------------------
// pipelined_chunk_adder
//   WIDTH-bit adder/subtractor split into STAGES chunks of CHUNK=WIDTH/STAGES
//   bits. Stage s adds chunk s with the registered carry from stage s-1, so the
//   longest carry path is one CHUNK-bit ripple. Operand chunks not yet added
//   ride forward through the stage records, and finished sum chunks ride along
//   with them so the whole result leaves the last stage aligned.
//
//   Optional feature: define PCA_OVF_EN to add the ovf port (signed overflow
//   of the full-width result, registered with sum).
//
//   Parameters:
//     WIDTH   operand/result width, multiple of STAGES, at most PCA_MAX_W
//     STAGES  pipeline stages and chunks (1..WIDTH)
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   operand beat valid
//     in_ready   out  beat accepted this cycle if in_valid
//     a, b       in   operands
//     cin        in   carry-in (ignored when sub=1)
//     sub        in   1: a-b, 0: a+b+cin
//     out_valid  out  result beat valid
//     out_ready  in   consumer takes the result
//     sum        out  result
//     cout       out  carry-out of bit WIDTH-1 (1 = no borrow on subtract)
//     ovf        out  signed overflow (PCA_OVF_EN only)
//
//   Handshake: a beat transfers on any rising edge where valid && ready are
//   both high on that side. The whole pipeline advances on one enable,
//   en = !out_valid || out_ready, and in_ready is en itself, so in_ready
//   depends combinationally on out_ready but never on in_valid. Bubbles are
//   kept in place rather than squeezed out.
// -----------------------------------------------------------------------------
module pipelined_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = PCA_WIDTH_DEF,
    parameter int STAGES = PCA_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PCA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    // Stage registers and the values each stage would load next.
    stage_t r   [STAGES];
    stage_t src [STAGES];
    stage_t nxt [STAGES];
    stage_t first;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    logic [STAGES-1:0][CHUNK-1:0] ch_a;
    logic [STAGES-1:0][CHUNK-1:0] ch_b;
    logic [STAGES-1:0][CHUNK-1:0] ch_sum;
    logic [STAGES-1:0]            ch_cin;
    logic [STAGES-1:0]            ch_cout;
    logic [STAGES-1:0]            ch_cmsb;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = r[LAST].valid;

    // Subtraction is a + ~b + 1; cin is not used in that mode.
    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? 1'b1 : cin;

    // Record entering stage 0. Because stage 0 only loads when en (== in_ready)
    // is high, in_valid alone decides whether the loaded slot is a beat or a
    // bubble.
    always_comb begin
        first       = '0;
        first.valid = in_valid;
        first.carry = c0;
        first.a     = PCA_MAX_W'(a);
        first.b     = PCA_MAX_W'(b_eff);
    end

    // ------------------------------------------------------------------
    // Per-stage chunk adders
    // ------------------------------------------------------------------
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign src[s] = first;
        end else begin : g_body
            assign src[s] = r[s-1];
        end

        // The carry entering chunk s is the carry field of the record feeding
        // this stage: c0 for stage 0, the registered chunk carry otherwise.
        assign ch_a[s]   = src[s].a[chunk_lo(s, CHUNK) +: CHUNK];
        assign ch_b[s]   = src[s].b[chunk_lo(s, CHUNK) +: CHUNK];
        assign ch_cin[s] = src[s].carry;

        rca_chunk #(
            .CHUNK (CHUNK)
        ) u_rca (
            .a         (ch_a[s]),
            .b         (ch_b[s]),
            .cin       (ch_cin[s]),
            .sum       (ch_sum[s]),
            .cout      (ch_cout[s]),
            .carry_msb (ch_cmsb[s])
        );
    end

    // Next-state records: pass everything forward, drop in this stage's sum
    // chunk and replace the carry with the chunk carry-out.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            nxt[s]       = src[s];
            nxt[s].carry = ch_cout[s];
            nxt[s].psum[chunk_lo(s, CHUNK) +: CHUNK] = ch_sum[s];
`ifdef PCA_OVF_EN
            // Only the last stage's value reaches ovf; there the chunk MSB is
            // bit WIDTH-1 of the full result.
            nxt[s].ovf = ch_cmsb[s] ^ ch_cout[s];
`else
            nxt[s].ovf = 1'b0;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage registers: all advance together on en, all hold otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r[s] <= '0;
            end
        end else if (en) begin
            for (int s = 0; s < STAGES; s++) begin
                r[s] <= nxt[s];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs straight from the last stage register.
    // ------------------------------------------------------------------
    assign sum  = r[LAST].psum[WIDTH-1:0];
    assign cout = r[LAST].carry;
`ifdef PCA_OVF_EN
    assign ovf  = r[LAST].ovf;
`endif

    // The last stage's operand copies, the upper record bits and (without
    // PCA_OVF_EN) the overflow terms have no consumer.
    logic unused_bits;
    assign unused_bits = ^{r[LAST].a, r[LAST].b, r[LAST].psum, r[LAST].ovf, ch_cmsb};

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
module tb_pipelined_chunk_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PCA_OVF_EN
    logic             ovf;
`endif

    pipelined_chunk_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PCA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
        string            name;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    // One beat through an otherwise empty pipeline with out_ready held high:
    // checks acceptance, latency, the result and that the beat drains.
    task automatic run_vec(input vec_t v);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a   = v.a;
        b   = v.b;
        cin = v.cin;
        sub = v.sub;
        #1;
        check({v.name, "_in_ready"}, 64'(in_ready), 64'd1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            lat++;
        end while (!out_valid && lat < 20);
        check({v.name, "_latency"}, 64'(lat), 64'(STAGES));
        check({v.name, "_sum"}, 64'(sum), 64'(v.exp_sum));
        check({v.name, "_cout"}, 64'(cout), 64'(v.exp_cout));
`ifdef PCA_OVF_EN
        check({v.name, "_ovf"}, 64'(ovf), 64'(v.exp_ovf));
`endif
        @(posedge clk); #1;
        check({v.name, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    int          sent;
    int          got;
    int          stall_cnt;
    bit          stalled;
    int          stale;
    logic [WIDTH-1:0] held_sum;

    initial begin
        vecs[0]  = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "wrap_zero"};
        vecs[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_5_7"};
        vecs[2]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, "sub_7_5"};
        vecs[3]  = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, "cross_chunks"};
        vecs[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf_add"};
        vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "ovf_sub"};
        vecs[6]  = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, "add_cin"};
        vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "all_ones_cin"};
        vecs[8]  = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "sub_equal"};
        vecs[9]  = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_borrow"};
        vecs[10] = '{32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "cin_ripple"};

        // reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        sub = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef PCA_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // table-driven single beats
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i]);
        end

        // back-to-back stream of 8 beats with a 3-cycle stall at first result
        sent = 0;
        got = 0;
        stall_cnt = 0;
        stalled = 1'b0;
        held_sum = '0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            if (out_valid && !stalled) begin
                stalled   = 1'b1;
                stall_cnt = 3;
                held_sum  = sum;
            end
            out_ready = (stall_cnt == 0);
            in_valid  = (sent < 8);
            a   = WIDTH'(sent);
            b   = WIDTH'(sent);
            cin = 1'b0;
            sub = 1'b0;
            #1;
            if (stall_cnt > 0) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_sum_hold", 64'(sum), 64'(held_sum));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stream_extra: got result %0h, expected no result", sum);
                end else begin
                    check("stream_sum", 64'(sum), 64'(exp_q.pop_front()));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(WIDTH'(2 * sent));
                sent++;
            end
            if (stall_cnt > 0) stall_cnt--;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 64'(got), 64'd8);
        check("stream_leftover", 64'(exp_q.size()), 64'd0);
        check("stream_stalled", 64'(stalled), 64'd1);
        repeat (STAGES + 1) @(posedge clk);
        #1;

        // reset with three beats in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = WIDTH'(100 + i);
            b = 32'h0000_0001;
            cin = 1'b0;
            sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("midrst_no_stale", 64'(stale), 64'd0);
        check("midrst_ready_after", 64'(in_ready), 64'd1);

        // recovery after reset
        run_vec(vecs[3]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
